// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter.
// wb_entry_t is the default-width FIFO entry; the arbiter rebuilds it for its own n/r.
package wb_pkg;
    localparam int N     = 16;
    localparam int R     = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [R-1:0] rd;
        logic [N-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LOAD} wb_src_e;
endpackage

// File: rtl/wb_arbiter_fifo.sv
// In-order load-result FIFO with circular pointers and an occupancy counter.
// The head entry is always visible on rdata; pop must only be asserted when non-empty.
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = wb_pkg::DEPTH,
    parameter int W     = $bits(wb_entry_t),
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register-file write port: ALU results beat buffered
// load results; a busy scoreboard tracks outstanding loads and stalls decode.
module wb_arbiter import wb_pkg::*; #(
    parameter int n     = wb_pkg::N,
    parameter int r     = wb_pkg::R,
    parameter int DEPTH = wb_pkg::DEPTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    input  logic [r-1:0]           alu_rd,
    input  logic [n-1:0]           alu_data,
    input  logic                   ld_issue,
    input  logic [r-1:0]           ld_issue_rd,
    input  logic                   ld_valid,
    input  logic [r-1:0]           ld_rd,
    input  logic [n-1:0]           ld_data,
    output logic                   ld_ready,
    input  logic [r-1:0]           dec_ra1,
    input  logic [r-1:0]           dec_ra2,
    input  logic [r-1:0]           dec_rd,
    input  logic                   dec_we,
    output logic                   hazard,
    output logic                   we3,
    output logic [r-1:0]           wa3,
    output logic [n-1:0]           wd3,
    output logic [2**r-1:0]        busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    typedef struct packed {
        logic [r-1:0] rd;
        logic [n-1:0] data;
    } entry_t;

    entry_t         push_e, head_e;
    logic           push, pop, full, empty;
    wb_src_e        src_d;
    logic [r-1:0]   wa3_d, wa3_q;
    logic [n-1:0]   wd3_d, wd3_q;
    logic           we3_q, wb_is_load_q;
    logic [2**r-1:0] busy_d, busy_q;

    // ld_ready comes from the registered count only, so a full FIFO refuses even on a pop cycle.
    assign ld_ready = ~full;
    assign push     = ld_valid & ld_ready & (ld_rd != '0);
    assign push_e   = '{rd: ld_rd, data: ld_data};

    wb_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .wdata  (push_e),
        .rdata  (head_e),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    // A write to r0 never claims the slot, letting the FIFO drain that cycle.
    always_comb begin
        src_d = WB_NONE;
        pop   = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (alu_valid && alu_rd != '0) begin
            src_d = WB_ALU;
            wa3_d = alu_rd;
            wd3_d = alu_data;
        end else if (!empty) begin
            src_d = WB_LOAD;
            pop   = 1'b1;
            wa3_d = head_e.rd;
            wd3_d = head_e.data;
        end
    end

    // Clear on the commit edge, then set, so a same-edge reissue keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (we3_q && wb_is_load_q) busy_d[wa3_q] = 1'b0;
        if (ld_issue && ld_issue_rd != '0) busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we3_q         <= 1'b0;
            wb_is_load_q  <= 1'b0;
            wa3_q         <= '0;
            wd3_q         <= '0;
            busy_q        <= '0;
        end else begin
            we3_q         <= (src_d != WB_NONE);
            wb_is_load_q  <= (src_d == WB_LOAD);
            wa3_q         <= wa3_d;
            wd3_q         <= wd3_d;
            busy_q        <= busy_d;
        end
    end

    assign hazard = busy_q[dec_ra1] | busy_q[dec_ra2] | (dec_we & busy_q[dec_rd]);
    assign we3    = we3_q;
    assign wa3    = wa3_q;
    assign wd3    = wd3_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued by the stimulus and
// a negedge monitor pops and compares every register-file write.
module tb_wb_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, ld_issue, ld_valid, dec_we;
    logic [2:0]  alu_rd, ld_issue_rd, ld_rd, dec_ra1, dec_ra2, dec_rd;
    logic [15:0] alu_data, ld_data;
    logic        ld_ready, hazard, we3;
    logic [2:0]  wa3;
    logic [15:0] wd3;
    logic [7:0]  busy;
    logic [1:0]  fifo_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    wb_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_rd(dec_rd), .dec_we(dec_we),
        .hazard(hazard), .we3(we3), .wa3(wa3), .wd3(wd3),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [2:0] rd, input logic [15:0] data);
        exp_t e;
        e.rd = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0; dec_we = 0;
    endtask

    // Scoreboard monitor: every write must match the next queued expectation.
    always @(negedge clock) begin
        if (reset_n && we3) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got wa3=%0d wd3=%0h expected no write", wa3, wd3);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wa3 !== e.rd || wd3 !== e.data) begin
                    failures++;
                    $display("FAIL write: got wa3=%0d wd3=%0h expected wa3=%0d wd3=%0h",
                             wa3, wd3, e.rd, e.data);
                end
            end
        end
    end

    // Reissuing a busy register is only legal on the edge that commits it.
    always @(posedge clock) begin
        if (reset_n && ld_issue && ld_issue_rd != 0 && busy[ld_issue_rd]) begin
            checks++;
            if (!(we3 && wa3 == ld_issue_rd)) begin
                failures++;
                $display("FAIL issue_busy: got ld_issue to busy rd=%0d expected no issue", ld_issue_rd);
            end
        end
    end

    logic        t_av [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic        t_lv [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [2:0]  t_lr [7] = '{1, 2, 4, 4, 4, 4, 0};
    logic [15:0] t_ld [7] = '{16'h1111, 16'h2222, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h0};
    logic        t_rdy[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [1:0]  t_cnt[7] = '{0, 1, 2, 2, 2, 1, 1};

    initial begin
        idle();
        reset_n = 1;
        #1 reset_n = 0;
        #2;
        chk("rst_we3", 32'(we3), 0);
        chk("rst_wa3", 32'(wa3), 0);
        chk("rst_wd3", 32'(wd3), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(ld_ready), 1);
        chk("rst_hazard", 32'(hazard), 0);
        step(); step();
        reset_n = 1;
        step();

        // ALU path: one-cycle latency, single-cycle write pulse
        alu_valid = 1; alu_rd = 3; alu_data = 16'h00A5;
        expect_wr(3, 16'h00A5);
        step();
        alu_valid = 0;
        chk("alu_we3", 32'(we3), 1);
        chk("alu_wa3", 32'(wa3), 3);
        chk("alu_wd3", 32'(wd3), 16'h00A5);
        step();
        chk("alu_we3_drop", 32'(we3), 0);
        chk("alu_wa3_hold", 32'(wa3), 3);

        // Load flow and hazard
        ld_issue = 1; ld_issue_rd = 5; dec_ra1 = 5;
        #1 chk("ld_hz_pre", 32'(hazard), 0);
        step();
        ld_issue = 0;
        #1;
        chk("ld_busy_set", 32'(busy), 32'h20);
        chk("ld_hz_ra1", 32'(hazard), 1);
        dec_ra1 = 0; dec_rd = 5; dec_we = 0;
        #1 chk("ld_hz_rd_nowe", 32'(hazard), 0);
        dec_we = 1;
        #1 chk("ld_hz_rd_we", 32'(hazard), 1);
        dec_we = 0; dec_rd = 0; dec_ra1 = 5;
        ld_valid = 1; ld_rd = 5; ld_data = 16'h1234;
        expect_wr(5, 16'h1234);
        step();
        ld_valid = 0;
        chk("ld_count1", 32'(fifo_count), 1);
        chk("ld_we3_t1", 32'(we3), 0);
        step();
        chk("ld_we3_t2", 32'(we3), 1);
        chk("ld_wa3_t2", 32'(wa3), 5);
        chk("ld_busy_t2", 32'(busy), 32'h20);
        chk("ld_hz_t2", 32'(hazard), 1);
        step();
        chk("ld_busy_t3", 32'(busy), 0);
        chk("ld_hz_t3", 32'(hazard), 0);
        idle();
        step();

        // Contention: ALU owns the port for 4 cycles while loads back up
        for (int c = 0; c < 4; c++) expect_wr(7, 16'hA000 + 16'(c));
        expect_wr(1, 16'h1111);
        expect_wr(2, 16'h2222);
        expect_wr(4, 16'h4444);
        for (int c = 0; c < 7; c++) begin
            alu_valid = t_av[c]; alu_rd = 7; alu_data = 16'hA000 + 16'(c);
            ld_valid = t_lv[c]; ld_rd = t_lr[c]; ld_data = t_ld[c];
            #1;
            chk($sformatf("cont_ready_c%0d", c), 32'(ld_ready), 32'(t_rdy[c]));
            chk($sformatf("cont_count_c%0d", c), 32'(fifo_count), 32'(t_cnt[c]));
            step();
        end
        idle();
        step(); step();
        chk("cont_drained", 32'(fifo_count), 0);
        chk("cont_all_written", 32'(exp_q.size()), 0);

        // Register zero handling
        alu_valid = 1; alu_rd = 5; alu_data = 16'h5555;
        ld_valid = 1; ld_rd = 3; ld_data = 16'h3333;
        expect_wr(5, 16'h5555);
        expect_wr(3, 16'h3333);
        step();
        alu_rd = 0; alu_data = 16'hDEAD;
        ld_rd = 0; ld_data = 16'hBEEF;
        #1;
        chk("z_count_b", 32'(fifo_count), 1);
        chk("z_ready_b", 32'(ld_ready), 1);
        step();
        idle();
        ld_issue = 1; ld_issue_rd = 0;
        #1;
        chk("z_count_c", 32'(fifo_count), 0);
        chk("z_wa3_c", 32'(wa3), 3);
        step();
        ld_issue = 0;
        chk("z_busy", 32'(busy), 0);
        chk("z_we3_d", 32'(we3), 0);
        step();

        // Set/clear collision on r6
        ld_issue = 1; ld_issue_rd = 6;
        step();
        ld_issue = 0;
        chk("col_busy_set", 32'(busy), 32'h40);
        ld_valid = 1; ld_rd = 6; ld_data = 16'h6666;
        expect_wr(6, 16'h6666);
        step();
        ld_valid = 0;
        step();
        ld_issue = 1; ld_issue_rd = 6;
        #1;
        chk("col_we3", 32'(we3), 1);
        chk("col_wa3", 32'(wa3), 6);
        step();
        ld_issue = 0;
        chk("col_busy_kept", 32'(busy), 32'h40);
        ld_valid = 1; ld_rd = 6; ld_data = 16'h6767;
        expect_wr(6, 16'h6767);
        step();
        ld_valid = 0;
        step(); step();
        chk("col_busy_clr", 32'(busy), 0);
        step();

        // Mid-stream reset with two queued loads
        ld_issue = 1; ld_issue_rd = 3;
        alu_valid = 1; alu_rd = 7; alu_data = 16'h7777;
        ld_valid = 1; ld_rd = 1; ld_data = 16'hAAAA;
        expect_wr(7, 16'h7777);
        expect_wr(7, 16'h7778);
        expect_wr(7, 16'h7779);
        step();
        ld_issue = 0;
        alu_data = 16'h7778; ld_rd = 2; ld_data = 16'hBBBB;
        step();
        alu_data = 16'h7779; ld_valid = 0;
        #1;
        chk("mr_count", 32'(fifo_count), 2);
        chk("mr_busy", 32'(busy), 32'h08);
        step();
        idle();
        @(negedge clock);
        #1 reset_n = 0;
        #1;
        chk("mr_we3", 32'(we3), 0);
        chk("mr_busy0", 32'(busy), 0);
        chk("mr_count0", 32'(fifo_count), 0);
        chk("mr_ready", 32'(ld_ready), 1);
        chk("mr_hazard", 32'(hazard), 0);
        step(); step();
        reset_n = 1;
        for (int i = 0; i < 5; i++) step();
        chk("mr_count_after", 32'(fifo_count), 0);
        chk("exp_leftover", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
